// File: rtl/rom_stream_pkg.sv
// Shared constants, FSM state type and beat payload for the ROM byte streamer.
// ZIGZAG_ORDER_EN adds the 8x8 zigzag scan table used to remap issued addresses.
package rom_stream_pkg;

    localparam int unsigned ADDR_W = 6;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } beat_t;

`ifdef ZIGZAG_ORDER_EN
    localparam logic [ADDR_W-1:0] ZZ_LUT [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };
`endif

    // Maps a linear walk position onto the ROM byte address actually read.
    function automatic logic [ADDR_W-1:0] map_addr(input logic [ADDR_W-1:0] pos);
`ifdef ZIGZAG_ORDER_EN
        return ZZ_LUT[pos];
`else
        return pos;
`endif
    endfunction

endpackage

// File: rtl/rom_byte_streamer_if.sv
// Valid/ready byte stream with a last flag; master drives data, slave drives ready.
interface rom_byte_streamer_if;

    logic                             valid;
    logic [rom_stream_pkg::DATA_W-1:0] data;
    logic                             last;
    logic                             ready;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/byte_fifo.sv
// Synchronous power-of-two FIFO with registered occupancy/full/empty and a
// combinational head read so the stream sees data the cycle it is written.
module byte_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata_c,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;
    logic [LVL_W-1:0] level_nx;

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        level_nx = level;
        case ({do_push, do_pop})
            2'b10:   level_nx = level + LVL_W'(1);
            2'b01:   level_nx = level - LVL_W'(1);
            default: level_nx = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            level <= level_nx;
            empty <= (level_nx == '0);
            full  <= (level_nx == LVL_W'(DEPTH));
        end
    end

    assign rdata_c = mem[rd_ptr];

endmodule

// File: rtl/rom_byte_streamer.sv
// Walks a run of ROM byte addresses, captures the 1-cycle-latency ROM data into
// a FIFO and streams it out with a last flag. ZIGZAG_ORDER_EN selects zigzag order.
module rom_byte_streamer
    import rom_stream_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [CNT_W-1:0]   count,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [DATA_W-1:0]  rom_dout,
    rom_byte_streamer_if.master m
);

    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
    localparam int unsigned CR_W  = LVL_W + 1;

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  idx;
    logic              issue_q;
    logic              issue_last_q;
    logic              tag_q;
    logic              tag_last_q;

    logic [LVL_W-1:0]  fifo_level;
    logic              fifo_full;
    logic              fifo_empty;
    beat_t             push_beat;
    beat_t             head_beat;

    logic              pop_c;
    logic              accept_c;
    logic              zero_cmd_c;
    logic              credit_c;
    logic              run_last_c;
    logic              drain_done_c;
    logic              issue_c;
    logic              issue_last_c;
    logic [ADDR_W-1:0] issue_addr_c;
    logic [CNT_W-1:0]  idx_nx;
    logic              busy_c;
    logic              done_c;

    assign pop_c      = m.valid && m.ready;
    assign accept_c   = (state == IDLE) && start && (count != '0);
    assign zero_cmd_c = (state == IDLE) && start && (count == '0);
    assign run_last_c = ((idx + CNT_W'(1)) == count_q);

    // Both the address stage and the data stage count against FIFO space.
    assign credit_c = ((CR_W'(fifo_level) + CR_W'(issue_q) + CR_W'(tag_q)) < CR_W'(DEPTH))
                      && !fifo_full;

    assign drain_done_c = !issue_q && !tag_q && (fifo_level == LVL_W'(1))
                          && pop_c && m.last;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next state
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept_c) state_nx = (count == CNT_W'(1)) ? DRAIN : RUN;
            RUN:     if (credit_c && run_last_c) state_nx = DRAIN;
            DRAIN:   if (drain_done_c) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // FSM outputs: read issue decision and next values of the status flags
    always_comb begin
        issue_c      = 1'b0;
        issue_last_c = 1'b0;
        issue_addr_c = rom_addr;
        idx_nx       = idx;
        busy_c       = (state_nx == RUN) || (state_nx == DRAIN);
        done_c       = (state_nx == DONE) || zero_cmd_c;
        case (state)
            IDLE: begin
                if (accept_c) begin
                    issue_c      = 1'b1;
                    issue_last_c = (count == CNT_W'(1));
                    issue_addr_c = map_addr(base_addr);
                    idx_nx       = CNT_W'(1);
                end
            end
            RUN: begin
                if (credit_c) begin
                    issue_c      = 1'b1;
                    issue_last_c = run_last_c;
                    issue_addr_c = map_addr(base_q + idx[ADDR_W-1:0]);
                    idx_nx       = idx + CNT_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Command latch, ROM address and the two-stage read tag pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q       <= '0;
            count_q      <= '0;
            idx          <= '0;
            rom_addr     <= '0;
            issue_q      <= 1'b0;
            issue_last_q <= 1'b0;
            tag_q        <= 1'b0;
            tag_last_q   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            if (accept_c) begin
                base_q  <= base_addr;
                count_q <= count;
            end
            if (issue_c) begin
                rom_addr <= issue_addr_c;
            end
            idx          <= idx_nx;
            issue_q      <= issue_c;
            issue_last_q <= issue_c && issue_last_c;
            tag_q        <= issue_q;
            tag_last_q   <= issue_last_q;
            busy         <= busy_c;
            done         <= done_c;
        end
    end

    assign push_beat = '{last: tag_last_q, data: rom_dout};

    byte_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(beat_t))
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (tag_q),
        .wdata   (push_beat),
        .pop     (pop_c),
        .rdata_c (head_beat),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    assign m.valid = !fifo_empty;
    assign m.data  = head_beat.data;
    assign m.last  = head_beat.last;

endmodule
